// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin arbiter in front of the 4:1 mux.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or after start, wrapping.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    always_comb begin
        logic [SEL_W-1:0] cand;
        // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
        idx   = start;
        found = 1'b0;
        cand  = start;
        // Walk from the farthest offset down so the nearest match is written last and wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = start + SEL_W'(k);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with bounded hold time; drives the select of a shared 4:1 mux.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int MAX_HOLD = 8,
    localparam int HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             new_grant
);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              ng_q, ng_d;

    logic [SEL_W-1:0]  pick_idx;
    logic              pick_found;
    logic              owner_req;
    logic              others_req;
    logic              at_limit;
    logic              take;

    // ptr always sits one past the current/last owner, so one picker serves both IDLE and rotation.
    rr_pick u_pick (
        .req   (req),
        .start (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign owner_req  = |(req & gnt_q);
    assign others_req = |(req & ~gnt_q);
    assign at_limit   = (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        ng_d    = 1'b0;
        take    = 1'b0;

        case (state_q)
            IDLE: take = pick_found;
            GRANT: begin
                if (!owner_req) begin
                    if (others_req) begin
                        take = 1'b1;
                    end else begin
                        // sel is left alone so the mux output stays stable while idle.
                        state_d = IDLE;
                        gnt_d   = '0;
                        hold_d  = '0;
                    end
                end else if (at_limit) begin
                    take   = others_req;
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d = GRANT;
            gnt_d   = onehot4(pick_idx);
            sel_d   = pick_idx;
            ptr_d   = pick_idx + SEL_W'(1);
            hold_d  = '0;
            ng_d    = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            ng_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            ng_q    <= ng_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign busy      = |gnt_q;
    assign new_grant = ng_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed stimulus pushes expectations, a monitor compares.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       new_grant;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       ng;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mux_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .new_grant (new_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Monitor: samples 1 time unit after every clock edge or reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({e.name, ".gnt"},  gnt,              e.gnt);
                check({e.name, ".sel"},  {2'b00, sel},     {2'b00, e.sel});
                check({e.name, ".busy"}, {3'b000, busy},   {3'b000, e.busy});
                check({e.name, ".ng"},   {3'b000, new_grant}, {3'b000, e.ng});
            end
        end
    end

    task automatic push(input logic [3:0] g, input logic [1:0] s, input logic b,
                        input logic n, input string nm);
        exp_t e;
        e.gnt  = g;
        e.sel  = s;
        e.busy = b;
        e.ng   = n;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Drive req at the falling edge; expectation describes outputs after the next rising edge.
    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                        input logic b, input logic n, input string nm);
        @(negedge clk);
        req = r;
        push(g, s, b, n, nm);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        req = 4'b0000;
        push(4'b0000, 2'b00, 1'b0, 1'b0, nm);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int o;
        rst = 1'b1;
        req = 4'b0000;

        step(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, "reset0");
        step(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, "reset1");
        @(negedge clk);
        rst = 1'b0;

        // Single requester: 1-cycle latency, one-cycle new_grant pulse, release to IDLE.
        step(4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1, "t1_first");
        step(4'b0001, 4'b0001, 2'b00, 1'b1, 1'b0, "t1_hold");
        step(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, "t1_release");

        // Full contention: 8 cycles per owner, rotation 0,1,2,3,0.
        do_reset("t2_reset");
        for (int c = 0; c < 33; c++) begin
            o = (c / 8) % 4;
            step(4'b1111, 4'b0001 << o, 2'(o), 1'b1, (c % 8) == 0, $sformatf("t2_c%0d", c));
        end
        step(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, "t2_release");

        // Owner 0 drops after 3 cycles with req2 pending: handover without idle gap.
        do_reset("t3_reset");
        step(4'b0101, 4'b0001, 2'b00, 1'b1, 1'b1, "t3_g0");
        step(4'b0101, 4'b0001, 2'b00, 1'b1, 1'b0, "t3_g1");
        step(4'b0101, 4'b0001, 2'b00, 1'b1, 1'b0, "t3_g2");
        step(4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1, "t3_handover");
        step(4'b0100, 4'b0100, 2'b10, 1'b1, 1'b0, "t3_after");

        // Lone requester 2 from IDLE for 20 cycles: hold counter wraps without new_grant.
        step(4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0, "t4_idle");
        for (int c = 0; c < 20; c++)
            step(4'b0100, 4'b0100, 2'b10, 1'b1, c == 0, $sformatf("t4_c%0d", c));

        // Release owner 2: sel holds in IDLE; then ptr=3 selects index 3 from 1001.
        step(4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0, "t5_idle0");
        step(4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0, "t5_idle1");
        step(4'b1001, 4'b1000, 2'b11, 1'b1, 1'b1, "t5_ptr3");

        // Owner 3 drops, req1 takes over; then asynchronous reset mid-grant.
        step(4'b0010, 4'b0010, 2'b01, 1'b1, 1'b1, "t6_g1");
        step(4'b0010, 4'b0010, 2'b01, 1'b1, 1'b0, "t6_hold");
        @(negedge clk);
        push(4'b0000, 2'b00, 1'b0, 1'b0, "t6_async");
        #2 rst = 1'b1;
        step(4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, "t6_in_reset");
        @(posedge clk);
        #2 rst = 1'b0;
        step(4'b1010, 4'b0010, 2'b01, 1'b1, 1'b1, "t6_restart");
        step(4'b1010, 4'b0010, 2'b01, 1'b1, 1'b0, "t6_restart_hold");

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
